grid_access_arbiter: RTL
========================

# grid_access_arbiter

Round-robin arbiter and sequencer that shares one single-port grid RAM (`memoryRAM`: 1-cycle registered read, synchronous write) among NREQ placement engines. It serialises grid reads and writes and adds an atomic claim operation: read a cell and, only if it holds EMPTY, write the requester's node id. This removes the check-then-write race when several placers run in parallel on the same grid.

## Interface
- NREQ, 4: number of requesting placement engines (2..8).
- ADDR_W, 32: grid address width.
- DATA_W, 32: grid word width.
- EMPTY, all ones (-1): value of a free grid cell.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request.
- op  in  2*NREQ  per-requester op, 2 bits each: 00 read, 01 write, 10 claim, 11 treated as read.
- addr  in  NREQ*ADDR_W  per-requester grid address.
- wdata  in  NREQ*DATA_W  per-requester write/claim data (node id).
- gnt  out  NREQ  one-hot, 1-cycle pulse: request accepted.
- done  out  NREQ  one-hot, 1-cycle pulse: operation complete.
- rdata  out  DATA_W  cell value read (read/claim); held until the next done.
- claim_ok  out  1  claim succeeded; held until the next done; 0 for read/write.
- mem_re, mem_we  out  1  grid RAM read/write enables.
- mem_addr  out  ADDR_W  grid RAM address.
- mem_din  out  DATA_W  grid RAM write data.
- mem_dout  in  DATA_W  grid RAM read data.

## Operation
- All outputs are registered. Reset value of every output: 0 (rdata 0, claim_ok 0, gnt 0, done 0, mem_* 0). Internal state: IDLE; rotate pointer ptr = 0.
- States: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE: req is sampled only here. The winner w is the first set req bit at or after ptr, wrapping modulo NREQ. Latch op[w], addr[w], wdata[w], then go to ISSUE. With no req set, stay in IDLE.
- ISSUE: gnt[w]=1 and mem_addr=latched addr.
  - Write: mem_we=1, mem_din=wdata, next state DONE.
  - Read/claim: mem_re=1, next state WAIT.
- WAIT: no enables asserted. mem_dout becomes valid in this cycle. Next state CHECK.
- CHECK: rdata <= mem_dout.
  - Claim with mem_dout == EMPTY: mem_we=1, mem_addr=addr, mem_din=wdata, claim_ok <= 1.
  - Any other case: claim_ok <= 0, no write.
  - Next state DONE.
- DONE: done[w]=1. rdata and claim_ok are valid. ptr <= (w+1) mod NREQ. Next state IDLE.
- Only one transaction is in flight at a time. Grid contents are never read or written except through these states.
- Requester rules:
  - Hold req, op, addr and wdata stable until gnt.
  - Deassert req no later than the cycle done is seen. A req still high in the IDLE cycle after DONE is treated as a new transaction.
- A write returns rdata unchanged from its previous value and claim_ok=0.
- Addresses are passed through unchecked. Range checking against the grid size is the requester's job.
- Reset at any edge aborts the transaction; the next cycle has all outputs 0. A write or claim whose mem_we was already presented remains in RAM. No done is issued for the aborted transaction.

## Timing
- Request sampled in IDLE cycle t. gnt at t+1.
- Write: mem_we at t+1, done at t+2. Back-to-back writes are served every 3 cycles.
- Read/claim: mem_re at t+1, mem_dout valid at t+2, claim write at t+3, done at t+4. Served every 5 cycles.
- Fairness: with NREQ requesters held continuously, each is served once per NREQ transactions. Worst-case wait before gnt: (NREQ-1)*5 + 1 cycles.
- Simultaneous claims to the same address are serialised. The first granted requester wins; all later ones see claim_ok=0 and rdata = winner's id.

## Test plan
- Write then read: req0 writes addr 7 data 3 (mem_we high 1 cycle at addr 7, done0 two cycles after sampling). req0 then reads addr 7 -> done0 4 cycles after sampling, rdata=3, claim_ok=0.
- Claim on a free cell: grid[12]=-1, req2 claims addr 12 id 5 -> mem_we at CHECK with din 5, claim_ok=1, rdata=-1. Then req1 claims addr 12 id 9 -> claim_ok=0, rdata=5, no mem_we.
- Round robin: after reset all four hold req (reads) continuously -> gnt order 0,1,2,3,0,1, one gnt every 5 cycles.
- Claim race: after reset req1 and req3 claim addr 4 (free) with ids 11 and 13 in the same cycle -> req1 claim_ok=1; req3 claim_ok=0 with rdata=11; grid[4]=11.
- Reset mid-operation: reset asserted during WAIT of req2's read -> next cycle all outputs 0, no done2. After release, req2 and req0 both pending -> req0 granted first (ptr=0).
- Idle: no req for 20 cycles -> mem_re, mem_we, gnt and done stay 0.

Source files
------------

// File: rtl/grid_access_arbiter_if.sv
// Grid access bus: NREQ placement engines on one side and the single-port
// grid RAM on the other, both connected to the arbiter.
//   req/op/addr/wdata : per-requester request, packed NREQ-wide
//   gnt/done          : one-hot accept / completion pulses
//   rdata/claim_ok    : result of the last completed operation
//   mem_*             : grid RAM port (1-cycle registered read)
// Modports: slave = arbiter view, master = requester/RAM view.
interface grid_access_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [NREQ-1:0]        req;
  logic [2*NREQ-1:0]      op;
  logic [NREQ*ADDR_W-1:0] addr;
  logic [NREQ*DATA_W-1:0] wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        done;
  logic [DATA_W-1:0]      rdata;
  logic                   claim_ok;
  logic                   mem_re;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_din;
  logic [DATA_W-1:0]      mem_dout;

  modport slave (
    input  req, op, addr, wdata, mem_dout,
    output gnt, done, rdata, claim_ok, mem_re, mem_we, mem_addr, mem_din
  );

  modport master (
    output req, op, addr, wdata, mem_dout,
    input  gnt, done, rdata, claim_ok, mem_re, mem_we, mem_addr, mem_din
  );
endinterface

// File: rtl/grid_access_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port grid RAM among NREQ
// placement engines. Serialises reads and writes, and provides an atomic
// claim (read a cell, write the node id only if the cell is EMPTY).
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : grid_access_arbiter_if.slave (requests, results, RAM port)
// All bus outputs are registered.
module grid_access_arbiter #(
  parameter int unsigned       NREQ   = 4,
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32,
  parameter logic [DATA_W-1:0] EMPTY  = '1
) (
  input logic                  clk,
  input logic                  reset,
  grid_access_arbiter_if.slave bus
);
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_q, win_d;
  logic              is_write_q, is_write_d;
  logic              is_claim_q, is_claim_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0] hold_rdata_q, hold_rdata_d;
  logic              hold_ok_q, hold_ok_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              claim_ok_q, claim_ok_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  // Per-requester views of the packed request fields.
  logic [1:0]        req_op    [NREQ];
  logic [ADDR_W-1:0] req_addr  [NREQ];
  logic [DATA_W-1:0] req_wdata [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign req_op[g]    = bus.op[2*g +: 2];
    assign req_addr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
    assign req_wdata[g] = bus.wdata[g*DATA_W +: DATA_W];
  end

  // Winner: first set req bit at or after ptr, wrapping.
  logic             any_req;
  logic [PTR_W-1:0] win_c;
  int unsigned      cand;

  always_comb begin
    any_req = 1'b0;
    win_c   = '0;
    cand    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_req && bus.req[PTR_W'(cand)]) begin
        any_req = 1'b1;
        win_c   = PTR_W'(cand);
      end
    end
  end

  // Next state and next values of every registered output. Each state
  // computes what the following cycle must present on the bus.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    win_d        = win_q;
    is_write_d   = is_write_q;
    is_claim_d   = is_claim_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    hold_rdata_d = hold_rdata_q;
    hold_ok_d    = hold_ok_q;
    rdata_d      = rdata_q;
    claim_ok_d   = claim_ok_q;
    gnt_d        = '0;
    done_d       = '0;
    mem_re_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_din_d    = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          win_d        = win_c;
          is_write_d   = (req_op[win_c] == 2'b01);
          is_claim_d   = (req_op[win_c] == 2'b10);
          lat_addr_d   = req_addr[win_c];
          lat_wdata_d  = req_wdata[win_c];
          gnt_d[win_c] = 1'b1;
          mem_addr_d   = req_addr[win_c];
          if (req_op[win_c] == 2'b01) begin
            mem_we_d  = 1'b1;
            mem_din_d = req_wdata[win_c];
          end else begin
            mem_re_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (is_write_q) begin
          done_d[win_q] = 1'b1;
          claim_ok_d    = 1'b0;
          state_d       = DONE;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Read data is only valid now; capture it and decide the claim here
        // so the conditional write lands in the CHECK cycle.
        hold_rdata_d = bus.mem_dout;
        hold_ok_d    = is_claim_q && (bus.mem_dout == EMPTY);
        if (is_claim_q && (bus.mem_dout == EMPTY)) begin
          mem_we_d   = 1'b1;
          mem_addr_d = lat_addr_q;
          mem_din_d  = lat_wdata_q;
        end
        state_d = CHECK;
      end
      CHECK: begin
        // Results become visible together with done and hold until the next one.
        done_d[win_q] = 1'b1;
        rdata_d       = hold_rdata_q;
        claim_ok_d    = hold_ok_q;
        state_d       = DONE;
      end
      DONE: begin
        ptr_d   = (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      win_q        <= '0;
      is_write_q   <= 1'b0;
      is_claim_q   <= 1'b0;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      hold_rdata_q <= '0;
      hold_ok_q    <= 1'b0;
      gnt_q        <= '0;
      done_q       <= '0;
      rdata_q      <= '0;
      claim_ok_q   <= 1'b0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      is_write_q   <= is_write_d;
      is_claim_q   <= is_claim_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      hold_rdata_q <= hold_rdata_d;
      hold_ok_q    <= hold_ok_d;
      gnt_q        <= gnt_d;
      done_q       <= done_d;
      rdata_q      <= rdata_d;
      claim_ok_q   <= claim_ok_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.claim_ok = claim_ok_q;
  assign bus.mem_re   = mem_re_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_din  = mem_din_q;

endmodule
